ahb_sram_slave: RTL

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_sram_slave.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave bridging to a single-port synchronous SRAM.
// Writes complete with zero wait states; reads take one wait state; misaligned accesses get a two-cycle ERROR.
module ahb_sram_slave #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              S_HSEL,
    input  logic [31:0]       S_HADDR,
    input  logic [1:0]        S_HTRANS,
    input  logic [2:0]        S_HSIZE,
    input  logic              S_HWRITE,
    input  logic [31:0]       S_HWDATA,
    input  logic              S_HREADY,
    output logic              S_HREADYOUT,
    output logic              S_HRESP,
    output logic [31:0]       S_HRDATA,
    output logic              sram_ce,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int unsigned BYTE_AW = ADDR_W + 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD      = 3'd2,
        RD_DATA = 3'd3,
        ERR1    = 3'd4,
        ERR2    = 3'd5
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BYTE_AW-1:0]   addr_q;
    logic [2:0]           size_q;
    logic                 accept;
    logic                 misaligned;
    logic [3:0]           lane_mask;

    // Address bits above the SRAM window alias; HTRANS[0] only separates SEQ from NONSEQ.
    logic unused_bits;
    assign unused_bits = ^{S_HADDR[31:BYTE_AW], S_HTRANS[0]};

    assign accept = S_HSEL && S_HTRANS[1] && S_HREADY &&
                    (state == IDLE || state == WR || state == RD_DATA || state == ERR2);

    assign misaligned = (S_HSIZE > 3'd2) ||
                        (S_HSIZE == 3'd1 && S_HADDR[0]) ||
                        (S_HSIZE == 3'd2 && S_HADDR[1:0] != 2'b00);

    // State and address-phase capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            size_q <= 3'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q <= S_HADDR[BYTE_AW-1:0];
                size_q <= S_HSIZE;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, WR, RD_DATA, ERR2: begin
                if (!accept)         state_next = IDLE;
                else if (misaligned) state_next = ERR1;
                else if (S_HWRITE)   state_next = WR;
                else                 state_next = RD;
            end
            RD:      state_next = RD_DATA;
            ERR1:    state_next = ERR2;
            default: state_next = IDLE;
        endcase
    end

    // Byte strobes for the latched write size and lane
    always_comb begin
        lane_mask = 4'b0000;
        unique case (size_q)
            3'd0:    lane_mask = 4'(4'b0001 << addr_q[1:0]);
            3'd1:    lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            3'd2:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    end

    assign sram_addr  = addr_q[BYTE_AW-1:2];
    assign sram_wdata = S_HWDATA;

    // Data-phase responses; reset forces the idle response and blocks any SRAM strobe.
    always_comb begin
        S_HREADYOUT = 1'b1;
        S_HRESP     = 1'b0;
        S_HRDATA    = 32'h0;
        sram_ce     = 1'b0;
        sram_we     = 4'b0000;
        if (!rst) begin
            unique case (state)
                WR: begin
                    sram_ce = 1'b1;
                    sram_we = lane_mask;
                end
                RD: begin
                    S_HREADYOUT = 1'b0;
                    sram_ce     = 1'b1;
                end
                RD_DATA: S_HRDATA = sram_rdata;
                ERR1: begin
                    S_HREADYOUT = 1'b0;
                    S_HRESP     = 1'b1;
                end
                ERR2:    S_HRESP = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
